cache_block_memory: RTL and testbench

- Block-granular backing data memory sitting directly downstream of the set-associative cache.
- Serves whole-block fills (read) and dirty-block write-backs (write) over the cache's memory handshake: read/write request, busywait, and one-cycle done pulses.
- Models a fixed multi-cycle access latency so the cache miss FSM (write-back, then fill, then done) is exercised realistically.
- One request in flight at a time.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/block_ram.sv | 32 +++
 rtl/cache_block_memory.sv | 122 ++++++++++++
 tb/tb_cache_block_memory.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Constants and encodings shared by the cache and its block-granular backing memory.
package cache_pkg;

    localparam int LINE_W           = 32;
    localparam int BLOCK_WORDS_LOG2 = 2;
    localparam int ADDR_W           = 32;
    localparam int BLOCK_W          = LINE_W * (2 ** BLOCK_WORDS_LOG2);
    localparam int BLK_ADDR_W       = ADDR_W - BLOCK_WORDS_LOG2 - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/block_ram.sv
// Block storage array: synchronous write, synchronous registered read.
// Only the read register is reset; the array contents survive reset.
module block_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 128
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cache_block_memory.sv
// Block-granular backing memory for the cache: one request at a time, fixed LATENCY
// wait cycles, then a one-cycle done pulse. All outputs come straight from flops.
module cache_block_memory
    import cache_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  m_read_i,
    input  logic                  m_wr_i,
    input  logic [BLK_ADDR_W-1:0] m_address_i,
    input  logic [BLOCK_W-1:0]    m_write_data_i,
    output logic [BLOCK_W-1:0]    m_read_data_o,
    output logic                  m_busywait_o,
    output logic                  m_read_done_o,
    output logic                  m_write_done_o,
    output mem_state_e            dbg_state_o
);

    localparam int CNT_W = 8;

    // Handshake: a request (m_read_i / m_wr_i level) is taken only in IDLE; busywait
    // covers the whole access and exactly one done pulse ends it. Write wins a tie.
    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    mem_op_e               op_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [BLOCK_W-1:0]    data_q;
    logic                  accept;
    logic                  ram_we;
    logic                  ram_re;
    logic                  busy_q;
    logic                  rdone_q;
    logic                  wdone_q;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^m_address_i[BLK_ADDR_W-1:DEPTH_LOG2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_wr_i || m_read_i) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    ram_we  = (op_q == OP_WRITE);
                    ram_re  = (op_q == OP_READ);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q   <= OP_READ;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= m_wr_i ? OP_WRITE : OP_READ;
            addr_q <= m_address_i[DEPTH_LOG2-1:0];
            data_q <= m_write_data_i;
        end
    end

    // Status flops are loaded from the next state so they line up with the state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q  <= 1'b0;
            rdone_q <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            busy_q  <= (state_d == WAIT);
            rdone_q <= (state_d == RESP) && (op_q == OP_READ);
            wdone_q <= (state_d == RESP) && (op_q == OP_WRITE);
        end
    end

    block_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (BLOCK_W)
    ) u_block_ram (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we      (ram_we),
        .re      (ram_re),
        .addr    (addr_q),
        .wdata   (data_q),
        .rdata   (m_read_data_o)
    );

    assign m_busywait_o   = busy_q;
    assign m_read_done_o  = rdone_q;
    assign m_write_done_o = wdone_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_cache_block_memory.sv
// Directed bench for cache_block_memory: timing model checked every cycle plus literal checks.
module tb_cache_block_memory;
  import cache_pkg::*;

  localparam int LAT0 = 4;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;

  logic                  m_read_i = 1'b0;
  logic                  m_wr_i = 1'b0;
  logic [BLK_ADDR_W-1:0] m_address_i = '0;
  logic [BLOCK_W-1:0]    m_write_data_i = '0;
  logic [BLOCK_W-1:0]    m_read_data_o;
  logic                  m_busywait_o;
  logic                  m_read_done_o;
  logic                  m_write_done_o;
  mem_state_e            dbg_state_o;

  logic                  rd1 = 1'b0;
  logic                  wr1 = 1'b0;
  logic [BLK_ADDR_W-1:0] addr1 = '0;
  logic [BLOCK_W-1:0]    wdata1 = '0;
  logic [BLOCK_W-1:0]    rdata1;
  logic                  busy1;
  logic                  rdone1;
  logic                  wdone1;
  mem_state_e            st1;

  int checks = 0;
  int failures = 0;

  cache_block_memory #(.DEPTH_LOG2(8), .LATENCY(LAT0)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .m_read_i       (m_read_i),
    .m_wr_i         (m_wr_i),
    .m_address_i    (m_address_i),
    .m_write_data_i (m_write_data_i),
    .m_read_data_o  (m_read_data_o),
    .m_busywait_o   (m_busywait_o),
    .m_read_done_o  (m_read_done_o),
    .m_write_done_o (m_write_done_o),
    .dbg_state_o    (dbg_state_o)
  );

  cache_block_memory #(.DEPTH_LOG2(8), .LATENCY(1)) dut_lat1 (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .m_read_i       (rd1),
    .m_wr_i         (wr1),
    .m_address_i    (addr1),
    .m_write_data_i (wdata1),
    .m_read_data_o  (rdata1),
    .m_busywait_o   (busy1),
    .m_read_done_o  (rdone1),
    .m_write_done_o (wdone1),
    .dbg_state_o    (st1)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // behavioural model: an access accepted at the end of cycle a is busy in a+1..a+LAT
  // and completes in cycle a+LAT+1; the next one may be taken at the end of a+LAT+2.
  logic [BLOCK_W-1:0] model_mem [256];
  bit                 model_known [256];
  logic [BLOCK_W-1:0] exp_q[$];
  bit                 p_valid = 1'b0;
  bit                 p_write = 1'b0;
  int                 p_end = -100;
  logic [7:0]         p_addr = '0;
  logic [BLOCK_W-1:0] p_data = '0;
  logic [BLOCK_W-1:0] exp_rd = '0;
  bit                 exp_rd_known = 1'b1;
  int                 cyc = 0;

  initial begin : compare
    bit exp_busy;
    bit exp_rdone;
    bit exp_wdone;
    bit done_cyc;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        check("rst_busy", m_busywait_o, 0);
        check("rst_rdone", m_read_done_o, 0);
        check("rst_wdone", m_write_done_o, 0);
        check("rst_rdata", m_read_data_o, 0);
        p_valid = 1'b0;
        exp_rd = '0;
        exp_rd_known = 1'b1;
      end else begin
        done_cyc  = p_valid && (cyc == p_end + LAT0 + 1);
        exp_busy  = p_valid && (cyc > p_end) && (cyc <= p_end + LAT0);
        exp_rdone = done_cyc && !p_write;
        exp_wdone = done_cyc && p_write;
        if (done_cyc) begin
          if (p_write) begin
            model_mem[p_addr] = p_data;
            model_known[p_addr] = 1'b1;
          end else begin
            exp_rd = model_mem[p_addr];
            exp_rd_known = model_known[p_addr];
          end
        end
        check("busywait", m_busywait_o, exp_busy);
        check("read_done", m_read_done_o, exp_rdone);
        check("write_done", m_write_done_o, exp_wdone);
        if (exp_rd_known) check("read_data", m_read_data_o, exp_rd);
        if (!(p_valid && cyc < p_end + LAT0 + 2) && (m_read_i || m_wr_i)) begin
          p_valid = 1'b1;
          p_end   = cyc;
          p_write = m_wr_i;
          p_addr  = m_address_i[7:0];
          p_data  = m_write_data_i;
        end
      end
      cyc++;
    end
  end

  // driver tasks
  task automatic drive(input logic rd, input logic wr, input logic [BLK_ADDR_W-1:0] a,
                       input logic [BLOCK_W-1:0] d);
    @(posedge clk_i); #1;
    m_read_i = rd;
    m_wr_i = wr;
    m_address_i = a;
    m_write_data_i = d;
  endtask

  task automatic release_req();
    @(posedge clk_i); #1;
    m_read_i = 1'b0;
    m_wr_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (m_read_done_o || m_write_done_o) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [BLK_ADDR_W-1:0] a,
                        input logic [BLOCK_W-1:0] d, input string name);
    drive(rd, wr, a, d);
    wait_done(name);
    release_req();
  endtask

  // Literal timing for LATENCY=4: accepted at end of cycle c, busy c+1..c+4, done c+5.
  task automatic timed_access(input logic wr, input logic [BLK_ADDR_W-1:0] a,
                              input logic [BLOCK_W-1:0] d);
    drive(!wr, wr, a, d);
    @(negedge clk_i);
    check("t_accept_cycle_busy", m_busywait_o, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      check("t_wait_busy", m_busywait_o, 1);
      check("t_wait_done", m_read_done_o | m_write_done_o, 0);
    end
    @(negedge clk_i);
    check("t_resp_busy", m_busywait_o, 0);
    check("t_resp_rdone", m_read_done_o, !wr);
    check("t_resp_wdone", m_write_done_o, wr);
    release_req();
  endtask

  // Literal timing for LATENCY=1 instance: busy only in c+1, done in c+2.
  task automatic lat1_access(input logic wr, input logic [BLK_ADDR_W-1:0] a,
                             input logic [BLOCK_W-1:0] d, input logic [BLOCK_W-1:0] exp_data);
    @(posedge clk_i); #1;
    rd1 = !wr;
    wr1 = wr;
    addr1 = a;
    wdata1 = d;
    @(negedge clk_i);
    check("l1_accept_busy", busy1, 0);
    @(negedge clk_i);
    check("l1_wait_busy", busy1, 1);
    check("l1_wait_done", rdone1 | wdone1, 0);
    @(negedge clk_i);
    check("l1_resp_busy", busy1, 0);
    check("l1_resp_rdone", rdone1, !wr);
    check("l1_resp_wdone", wdone1, wr);
    if (!wr) check("l1_rdata", rdata1, exp_data);
    @(posedge clk_i); #1;
    rd1 = 1'b0;
    wr1 = 1'b0;
    @(negedge clk_i);
    check("l1_after_busy", busy1, 0);
    check("l1_after_done", rdone1 | wdone1, 0);
  endtask

  localparam logic [BLOCK_W-1:0] BLK_A5 = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [BLOCK_W-1:0] BLK_C3 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
  localparam logic [BLOCK_W-1:0] BLK_A1 = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
  localparam logic [BLOCK_W-1:0] BLK_B1 = 128'hBBBB0001_BBBB0002_BBBB0003_BBBB0004;

  initial begin : stimulus
    int extra;
    repeat (3) @(negedge clk_i);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // write block 5, then read it back, both with literal timing
    timed_access(1'b1, 28'h5, BLK_A5);
    timed_access(1'b0, 28'h5, '0);
    check("rd5_data", m_read_data_o, BLK_A5);

    // read request held for one cycle only: access still completes, exactly once
    drive(1'b1, 1'b0, 28'h5, '0);
    release_req();
    wait_done("drop_done");
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (m_busywait_o || m_read_done_o || m_write_done_o) extra++;
    end
    check("drop_no_second", extra, 0);

    // reset during a write must leave the previous contents
    access(1'b0, 1'b1, 28'h3, BLK_C3, "wr3_done");
    drive(1'b0, 1'b1, 28'h3, '1);
    @(posedge clk_i); #1;
    m_wr_i = 1'b0;
    reset_i = 1'b1;
    #1;
    check("midrst_busy", m_busywait_o, 0);
    check("midrst_rdata", m_read_data_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    access(1'b1, 1'b0, 28'h3, '0, "rd3_done");
    check("rd3_data", m_read_data_o, BLK_C3);

    // simultaneous write and read: write first, held read serviced afterwards
    drive(1'b1, 1'b1, 28'h7, 128'h1234);
    wait_done("sim_wr_done");
    check("sim_only_wdone", m_read_done_o, 0);
    @(posedge clk_i); #1;
    m_wr_i = 1'b0;
    wait_done("sim_rd_done");
    check("sim_rdone", m_read_done_o, 1);
    check("sim_rdata", m_read_data_o, 128'h1234);
    release_req();

    // back-to-back writes to aliasing addresses, then read the low alias
    drive(1'b0, 1'b1, 28'h001, BLK_A1);
    wait_done("b2b_first_done");
    @(posedge clk_i); #1;
    m_address_i = 28'h101;
    m_write_data_i = BLK_B1;
    @(negedge clk_i);
    check("b2b_idle_gap", m_busywait_o, 0);
    wait_done("b2b_second_done");
    release_req();
    access(1'b1, 1'b0, 28'h001, '0, "alias_rd_done");
    check("alias_rdata", m_read_data_o, BLK_B1);

    // LATENCY=1 instance
    lat1_access(1'b1, 28'h9, 128'h5555_0000_0000_0009, '0);
    lat1_access(1'b0, 28'h9, '0, 128'h5555_0000_0000_0009);

    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
